// File: rtl/adder_pkg.sv
// Shared widths and elaboration helpers for the pipelined adder tree.
package adder_pkg;

  localparam int unsigned DEF_NUM_IN = 16;
  localparam int unsigned DEF_IN_W   = 19;
  localparam int unsigned DEF_OUT_W  = 23;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One registered level of the adder tree: pairwise sums plus a valid bit, frozen when en is low.
module adder_tree_stage #(
  parameter int unsigned NUM_PAIRS = 1,
  parameter int unsigned W         = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic [2*NUM_PAIRS*W-1:0] in_data,
  output logic                     out_valid,
  output logic [NUM_PAIRS*W-1:0]   out_data
);

  logic [NUM_PAIRS*W-1:0] sum_d, sum_q;
  logic                   valid_q;

  always_comb begin
    sum_d = '0;
    for (int p = 0; p < int'(NUM_PAIRS); p++) begin
      sum_d[p*W +: W] = in_data[2*p*W +: W] + in_data[(2*p+1)*W +: W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
    end else if (en) begin
      valid_q <= in_valid;
      sum_q   <= sum_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = sum_q;

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined signed adder tree with per-channel enable, global stall and saturating/wrapping output.
module pipelined_adder_tree
  import adder_pkg::*;
#(
  parameter int unsigned NUM_IN   = DEF_NUM_IN,
  parameter int unsigned IN_W     = DEF_IN_W,
  parameter int unsigned OUT_W    = DEF_OUT_W,
  parameter int unsigned SATURATE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_IN*IN_W-1:0] in_data,
  input  logic [NUM_IN-1:0]      ch_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_sum,
  output logic                   overflow
);

  localparam int unsigned L        = clog2(NUM_IN);
  localparam int unsigned FULL_W   = IN_W + L;
  localparam int unsigned NUM_LEAF = 1 << L;

  // All tree levels packed end to end: level i starts at 2*(NUM_LEAF - (NUM_LEAF >> i)) words.
  logic [(2*NUM_LEAF-1)*FULL_W-1:0] tree;
  logic [L:0]                       lvl_valid;
  logic                             advance;

  assign advance      = in_ready;
  assign lvl_valid[0] = in_valid;

  for (genvar k = 0; k < int'(NUM_LEAF); k++) begin : g_leaf
    if (k < int'(NUM_IN)) begin : g_ch
      logic [IN_W-1:0] x;
      assign x = in_data[k*IN_W +: IN_W];
      assign tree[k*FULL_W +: FULL_W] = ch_en[k] ? {{L{x[IN_W-1]}}, x} : '0;
    end else begin : g_pad
      assign tree[k*FULL_W +: FULL_W] = '0;
    end
  end

  for (genvar i = 0; i < int'(L); i++) begin : g_lvl
    localparam int unsigned IN_OFF  = 2 * (NUM_LEAF - (NUM_LEAF >> i));
    localparam int unsigned OUT_OFF = 2 * (NUM_LEAF - (NUM_LEAF >> (i + 1)));
    localparam int unsigned NP      = NUM_LEAF >> (i + 1);

    adder_tree_stage #(
      .NUM_PAIRS(NP),
      .W        (FULL_W)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (advance),
      .in_valid (lvl_valid[i]),
      .in_data  (tree[IN_OFF*FULL_W +: 2*NP*FULL_W]),
      .out_valid(lvl_valid[i+1]),
      .out_data (tree[OUT_OFF*FULL_W +: NP*FULL_W])
    );
  end

  // The last level's register is the output register; range handling is purely combinational
  // on it, so it adds no latency and stays stable whenever the pipeline is stalled.
  logic [FULL_W-1:0]       full_sum;
  logic [FULL_W-OUT_W:0]   top_bits;
  logic                    out_of_range;

  assign full_sum     = tree[(2*NUM_LEAF-2)*FULL_W +: FULL_W];
  assign top_bits     = full_sum[FULL_W-1:OUT_W-1];
  assign out_of_range = !((top_bits == '0) || (top_bits == '1));

  always_comb begin
    out_sum  = full_sum[OUT_W-1:0];
    overflow = out_of_range;
    if ((SATURATE != 0) && out_of_range) begin
      out_sum = full_sum[FULL_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  assign out_valid = lvl_valid[L];
  assign in_ready  = !(out_valid && !out_ready);

endmodule
